// File: rtl/frame_rx_if.sv
// Handshake, GMII, MAC-side and CRC-unit signals of the frame receiver.
// The receiver itself connects through the slave modport.
interface frame_rx_if;
  logic        fs;
  logic        fd;
  logic        eth_rxrdy;
  logic [7:0]  rxd;
  logic        rxdv;
  logic [7:0]  mac_rxd;
  logic        mac_rxdv;
  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [10:0] frame_len;

  modport master (
    output fs, rxd, rxdv, crc,
    input  fd, eth_rxrdy, mac_rxd, mac_rxdv, crc_clr, crc_en, crc_din,
           frame_ok, err_code, frame_len
  );

  modport slave (
    input  fs, rxd, rxdv, crc,
    output fd, eth_rxrdy, mac_rxd, mac_rxdv, crc_clr, crc_en, crc_din,
           frame_ok, err_code, frame_len
  );
endinterface

// File: rtl/frame_rx.sv
// GMII frame receiver: preamble/SFD hunt, FCS-stripped payload forwarding,
// external CRC32 feed and end-of-frame status reporting.
module frame_rx #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned PRE_MAX = 7
) (
  input  logic       clk,
  input  logic       rst,
  frame_rx_if.slave  bus
);

  localparam int unsigned PW = $clog2(PRE_MAX + 1);
  localparam logic [10:0]   MIN_L = 11'(MIN_LEN);
  localparam logic [10:0]   MAX_L = 11'(MAX_LEN);
  localparam logic [PW-1:0] PRE_M = PW'(PRE_MAX);

  typedef enum logic [2:0] {
    IDLE, WAIT, HUNT, PRE, DATA, CHK, DROP, DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [10:0]   cnt, cnt_nx;
  logic [31:0]   sh, sh_nx;
  logic [7:0]    mac_rxd_q, mac_rxd_nx;
  logic          mac_rxdv_q, mac_rxdv_nx;
  logic          crc_clr_q, crc_clr_nx;
  logic          frame_ok_q, frame_ok_nx;
  logic [1:0]    err_q, err_nx;
  logic [10:0]   len_q, len_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      cnt        <= '0;
      sh         <= '0;
      mac_rxd_q  <= '0;
      mac_rxdv_q <= 1'b0;
      crc_clr_q  <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= '0;
      len_q      <= '0;
    end else begin
      state      <= state_nx;
      pcnt       <= pcnt_nx;
      cnt        <= cnt_nx;
      sh         <= sh_nx;
      mac_rxd_q  <= mac_rxd_nx;
      mac_rxdv_q <= mac_rxdv_nx;
      crc_clr_q  <= crc_clr_nx;
      frame_ok_q <= frame_ok_nx;
      err_q      <= err_nx;
      len_q      <= len_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pcnt_nx     = pcnt;
    cnt_nx      = cnt;
    sh_nx       = sh;
    mac_rxd_nx  = mac_rxd_q;
    mac_rxdv_nx = 1'b0;
    crc_clr_nx  = 1'b0;
    frame_ok_nx = frame_ok_q;
    err_nx      = err_q;
    len_nx      = len_q;

    unique case (state)
      IDLE: state_nx = WAIT;

      WAIT: if (bus.fs && !bus.rxdv) state_nx = HUNT;

      HUNT: begin
        if (!bus.fs) begin
          state_nx = WAIT;
        end else if (bus.rxdv) begin
          if (bus.rxd == 8'h55) begin
            state_nx = PRE;
            pcnt_nx  = PW'(1);
          end else begin
            state_nx = DROP;
          end
        end
      end

      PRE: begin
        if (!bus.rxdv) begin
          state_nx = HUNT;
        end else if (bus.rxd == 8'h55) begin
          if (pcnt < PRE_M) pcnt_nx = pcnt + PW'(1);
          else              state_nx = DROP;
        end else if (bus.rxd == 8'hD5) begin
          state_nx   = DATA;
          crc_clr_nx = 1'b1;
          cnt_nx     = '0;
        end else begin
          state_nx = DROP;
        end
      end

      DATA: begin
        if (bus.rxdv) begin
          sh_nx  = {sh[23:0], bus.rxd};
          cnt_nx = (cnt == '1) ? cnt : cnt + 11'd1;
          // Four-byte delay line: a byte leaves the top of sh only once four
          // newer bytes exist, so the trailing FCS is never forwarded.
          if (cnt >= 11'd4 && cnt < MAX_L) begin
            mac_rxd_nx  = sh[31:24];
            mac_rxdv_nx = 1'b1;
          end
        end else begin
          state_nx = CHK;
        end
      end

      CHK: begin
        state_nx = DONE;
        if (cnt < MIN_L)      err_nx = 2'd2;
        else if (cnt > MAX_L) err_nx = 2'd3;
        else if (bus.crc != sh) err_nx = 2'd1;
        else                  err_nx = 2'd0;
        frame_ok_nx = (err_nx == 2'd0);
        len_nx      = (cnt < 11'd4) ? '0 : cnt - 11'd4;
      end

      DROP: if (!bus.rxdv) state_nx = HUNT;

      DONE: if (!bus.fs) state_nx = WAIT;

      default: state_nx = IDLE;
    endcase
  end

  assign bus.fd        = (state == DONE);
  assign bus.eth_rxrdy = (state == HUNT);
  assign bus.mac_rxd   = mac_rxd_q;
  assign bus.mac_rxdv  = mac_rxdv_q;
  assign bus.crc_din   = mac_rxd_q;
  assign bus.crc_en    = mac_rxdv_q;
  assign bus.crc_clr   = crc_clr_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.err_code  = err_q;
  assign bus.frame_len = len_q;

endmodule

// File: tb/tb_frame_rx.sv
// Scoreboard bench for frame_rx with a behavioural Ethernet CRC32 unit
// standing in for the shared external CRC block.
module tb_frame_rx;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned PRE_MAX = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_rx_if bus();

  frame_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PRE_MAX(PRE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // External CRC unit: reflected CRC32, result presented first-wire-byte in [31:24]
  logic [31:0] crc_r = '1;
  always @(posedge clk) begin
    if (bus.crc_clr)     crc_r <= '1;
    else if (bus.crc_en) crc_r <= crc_step(crc_r, bus.crc_din);
  end
  assign bus.crc = {~crc_r[7:0], ~crc_r[15:8], ~crc_r[23:16], ~crc_r[31:24]};

  typedef struct packed {
    logic        ok;
    logic [1:0]  err;
    logic [10:0] len;
  } stat_t;

  logic [7:0] exp_mac[$];
  stat_t      exp_stat[$];
  logic [7:0] pay[$];
  logic       fd_d = 1'b0;
  logic       lat_armed = 1'b0;
  int unsigned lat_c0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mac_rxdv || bus.crc_en) begin
        if (exp_mac.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mac: got mac_rxd=%0h crc_en=%0b expected no output",
                   bus.mac_rxd, bus.crc_en);
        end else begin
          logic [7:0] e;
          e = exp_mac.pop_front();
          check("mac_rxd", 32'(bus.mac_rxd), 32'(e));
          check("crc_din", 32'(bus.crc_din), 32'(e));
          check("mac_rxdv", 32'(bus.mac_rxdv), 32'd1);
          check("crc_en", 32'(bus.crc_en), 32'd1);
        end
        if (lat_armed) begin
          // byte sampled on edge c0 appears after edge c0+4 (fifth edge counting c0)
          check("first_byte_latency", cyc, lat_c0 + 4);
          lat_armed = 1'b0;
        end
      end
      if (bus.fd && !fd_d) begin
        if (exp_stat.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fd: got fd=1 expected no frame done");
        end else begin
          stat_t s;
          s = exp_stat.pop_front();
          check("frame_ok", 32'(bus.frame_ok), 32'(s.ok));
          check("err_code", 32'(bus.err_code), 32'(s.err));
          check("frame_len", 32'(bus.frame_len), 32'(s.len));
        end
      end
      fd_d = bus.fd;
    end else begin
      fd_d = 1'b0;
    end
  end

  task automatic drive(input logic [7:0] b, input logic dv);
    @(negedge clk);
    bus.rxd  = b;
    bus.rxdv = dv;
  endtask

  task automatic build(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(i));
  endtask

  task automatic push_mac(input int n);
    for (int i = 0; i < n; i++) exp_mac.push_back(pay[i]);
  endtask

  task automatic push_stat(input logic ok, input logic [1:0] err, input logic [10:0] len);
    stat_t s;
    s.ok = ok; s.err = err; s.len = len;
    exp_stat.push_back(s);
  endtask

  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    c = '1;
    foreach (pay[i]) c = crc_step(c, pay[i]);
    return {~c[7:0], ~c[15:8], ~c[23:16], ~c[31:24]};
  endfunction

  task automatic send_frame(input int npre, input logic bad_fcs, input logic lat);
    logic [31:0] fcs;
    fcs = fcs_of();
    if (bad_fcs) fcs[15:8] = fcs[15:8] ^ 8'h01;
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    foreach (pay[i]) begin
      drive(pay[i], 1'b1);
      if (i == 0 && lat) begin
        lat_c0    = cyc + 1;
        lat_armed = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) drive(fcs[31 - 8*k -: 8], 1'b1);
    drive(8'h00, 1'b0);
  endtask

  task automatic arm();
    int n;
    bus.fs = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.eth_rxrdy && n < 20);
    check("arm_eth_rxrdy", 32'(bus.eth_rxrdy), 32'd1);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.fd && n < 20);
    check("fd_seen", 32'(bus.fd), 32'd1);
    check("mac_queue_drained", 32'(exp_mac.size()), 32'd0);
    check("stat_queue_drained", 32'(exp_stat.size()), 32'd0);
  endtask

  task automatic disarm();
    bus.fs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fd"}, 32'(bus.fd), 32'd0);
    check({tag, "_eth_rxrdy"}, 32'(bus.eth_rxrdy), 32'd0);
    check({tag, "_mac_rxdv"}, 32'(bus.mac_rxdv), 32'd0);
    check({tag, "_crc_en"}, 32'(bus.crc_en), 32'd0);
    check({tag, "_crc_clr"}, 32'(bus.crc_clr), 32'd0);
    check({tag, "_mac_rxd"}, 32'(bus.mac_rxd), 32'd0);
    check({tag, "_status"}, {17'd0, bus.frame_ok, bus.err_code, bus.frame_len}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.fs = 1'b0; bus.rxd = '0; bus.rxdv = 1'b0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Good 60-byte frame; then fs held high keeps DONE, fs low returns to WAIT
    arm();
    build(60); push_mac(60); push_stat(1'b1, 2'd0, 11'd60);
    send_frame(7, 1'b0, 1'b1);
    wait_fd();
    repeat (10) @(negedge clk);
    #1;
    check("done_held_fd", 32'(bus.fd), 32'd1);
    bus.fs = 1'b0;
    @(negedge clk); #1;
    check("done_exit_fd", 32'(bus.fd), 32'd0);
    check("wait_eth_rxrdy", 32'(bus.eth_rxrdy), 32'd0);

    // FCS mismatch
    arm();
    build(60); push_mac(60); push_stat(1'b0, 2'd1, 11'd60);
    send_frame(7, 1'b1, 1'b0);
    wait_fd(); disarm();

    // Short frame
    arm();
    build(20); push_mac(20); push_stat(1'b0, 2'd2, 11'd20);
    send_frame(7, 1'b0, 1'b0);
    wait_fd(); disarm();

    // Long frame: 1600 bytes after SFD, forwarding stops after 1514
    arm();
    build(1596); push_mac(1514); push_stat(1'b0, 2'd3, 11'd1596);
    send_frame(7, 1'b0, 1'b0);
    wait_fd(); disarm();

    // Bad preamble byte -> dropped, then a good frame
    arm();
    drive(8'h55, 1'b1); drive(8'h55, 1'b1); drive(8'h12, 1'b1);
    for (int i = 0; i < 5; i++) drive(8'hA0 + 8'(i), 1'b1);
    drive(8'h00, 1'b0);
    @(negedge clk); #1;
    check("drop_no_fd", 32'(bus.fd), 32'd0);
    check("drop_back_to_hunt", 32'(bus.eth_rxrdy), 32'd1);
    build(60); push_mac(60); push_stat(1'b1, 2'd0, 11'd60);
    send_frame(7, 1'b0, 1'b0);
    wait_fd(); disarm();

    // Eight preamble bytes exceed the limit -> dropped
    arm();
    build(60);
    send_frame(8, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("long_pre_no_fd", 32'(bus.fd), 32'd0);
    check("long_pre_hunt", 32'(bus.eth_rxrdy), 32'd1);
    disarm();

    // fs rises mid-frame: frame ignored, HUNT only after rxdv falls
    build(60);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    for (int i = 0; i < 30; i++) drive(pay[i], 1'b1);
    bus.fs = 1'b1;
    for (int i = 30; i < 60; i++) drive(pay[i], 1'b1);
    @(negedge clk); #1;
    check("midframe_not_armed", 32'(bus.eth_rxrdy), 32'd0);
    drive(8'h00, 1'b0);
    @(negedge clk); #1;
    check("midframe_armed_after", 32'(bus.eth_rxrdy), 32'd1);
    push_mac(60); push_stat(1'b1, 2'd0, 11'd60);
    send_frame(7, 1'b0, 1'b0);
    wait_fd(); disarm();

    // Reset during payload byte 30: 26 bytes already forwarded, no fd
    arm();
    build(60); push_mac(26);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    for (int i = 0; i <= 30; i++) drive(pay[i], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_zero("midreset");
    check("midreset_mac_count", 32'(exp_mac.size()), 32'd0);
    bus.rxdv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    arm();
    push_mac(60); push_stat(1'b1, 2'd0, 11'd60);
    send_frame(7, 1'b0, 1'b0);
    wait_fd(); disarm();

    check("final_mac_queue", 32'(exp_mac.size()), 32'd0);
    check("final_stat_queue", 32'(exp_stat.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
